wb_cmd_master: RTL and testbench



---
 rtl/wb_defs.sv | 13 +
 rtl/wb_cmd_master_if.sv | 40 ++++
 rtl/wb_timeout_counter.sv | 21 ++
 rtl/wb_cmd_master.sv | 112 +++++++++++
 tb/tb_wb_cmd_master.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_defs.sv
// wb_defs: Wishbone state encoding and default bus widths shared by
// the command master and the slave modules.
package wb_defs;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int WB_DEF_DATA_WIDTH = 32;
    localparam int WB_DEF_ADDR_WIDTH = 32;
    localparam int WB_DEF_SEL_WIDTH  = 4;
endpackage

// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: command/response streams plus the Wishbone master bus.
interface wb_cmd_master_if import wb_defs::*; #(
    parameter int WB_DATA_WIDTH = WB_DEF_DATA_WIDTH,
    parameter int WB_ADDR_WIDTH = WB_DEF_ADDR_WIDTH,
    parameter int WB_SEL_WIDTH  = WB_DEF_SEL_WIDTH
);
    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic [WB_ADDR_WIDTH-1:0] cmd_addr_i;
    logic [WB_DATA_WIDTH-1:0] cmd_data_i;
    logic                     cmd_we_i;
    logic [WB_SEL_WIDTH-1:0]  cmd_sel_i;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [WB_DATA_WIDTH-1:0] rsp_data_o;
    logic                     rsp_err_o;
    logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
    logic [WB_DATA_WIDTH-1:0] wb_data_o;
    logic                     wb_we_o;
    logic [WB_SEL_WIDTH-1:0]  wb_sel_o;
    logic                     wb_stb_o;
    logic                     wb_cyc_o;
    logic                     wb_ack_i;
    logic                     wb_err_i;
    logic [WB_DATA_WIDTH-1:0] wb_data_i;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_we_i, cmd_sel_i, rsp_ready_i,
               wb_ack_i, wb_err_i, wb_data_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_we_i, cmd_sel_i, rsp_ready_i,
               wb_ack_i, wb_err_i, wb_data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: counts stalled bus cycles, saturating at TIMEOUT_CYCLES.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic en,
    output logic expired
);
    logic [W-1:0] cnt;

    assign expired = cnt == W'(TIMEOUT_CYCLES);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-transfer Wishbone classic initiator fed by a command stream.
// Define WB_CMD_MASTER_TIMEOUT_EN to abort BUS cycles that stall for TIMEOUT_CYCLES.
module wb_cmd_master import wb_defs::*; #(
    parameter int WB_DATA_WIDTH  = WB_DEF_DATA_WIDTH,
    parameter int WB_ADDR_WIDTH  = WB_DEF_ADDR_WIDTH,
    parameter int WB_SEL_WIDTH   = WB_DEF_SEL_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk_i,
    input logic              rst_n_i,
    wb_cmd_master_if.master  bus
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    wb_state_e                state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WB_DATA_WIDTH-1:0] data_q, data_d;
    logic                     we_q, we_d;
    logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                     cyc_q, cyc_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [WB_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     done;
    logic                     expired;

    assign done = bus.wb_ack_i || bus.wb_err_i;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (state_q != BUS),
        .en      (state_q == BUS && !done),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign bus.cmd_ready_o = state_q == IDLE;
    assign bus.wb_addr_o   = addr_q;
    assign bus.wb_data_o   = data_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_err_o   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = we_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (bus.cmd_valid_i) begin
                state_d = BUS;
                addr_d  = bus.cmd_addr_i;
                data_d  = bus.cmd_data_i;
                we_d    = bus.cmd_we_i;
                sel_d   = bus.cmd_sel_i;
                cyc_d   = 1'b1;
            end
            BUS: if (done || expired) begin
                // a real ack/err in the expiry cycle takes priority over the timeout
                state_d     = RESP;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = done ? bus.wb_err_i : 1'b1;
                rsp_data_d  = (done && !we_q && !bus.wb_err_i) ? bus.wb_data_i : '0;
            end
            RESP: if (bus.rsp_ready_i) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed vector table plus multi-cycle corner sequences
// against a small byte-select memory responder.
module tb_wb_cmd_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4)) bus ();

    wb_cmd_master #(
        .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    logic        ack_en = 1'b0;
    logic        err_mode = 1'b0;
    logic        stray = 1'b0;
    int          delay = 0;
    int          bcnt = 0;
    logic        hit;
    logic [31:0] mem [16];

    assign hit           = ack_en && bus.wb_cyc_o && bus.wb_stb_o && (bcnt == delay);
    assign bus.wb_ack_i  = stray || hit;
    assign bus.wb_err_i  = hit && err_mode;
    assign bus.wb_data_i = mem[bus.wb_addr_o[5:2]];

    always @(posedge clk) begin
        bcnt <= bus.wb_cyc_o ? bcnt + 1 : 0;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (hit && !err_mode && bus.wb_we_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.wb_sel_o[b]) mem[bus.wb_addr_o[5:2]][8*b +: 8] <= bus.wb_data_o[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor for the back-to-back sequence
    logic        mon = 1'b0;
    logic        cyc_prev;
    int          pulses, low_run, gap_bad, rdy_bad;
    logic [31:0] rq [$];

    always @(negedge clk) begin
        if (!mon) begin
            pulses = 0; low_run = 0; gap_bad = 0; rdy_bad = 0;
            cyc_prev = bus.wb_cyc_o;
            rq.delete();
        end else begin
            if (bus.wb_cyc_o && !cyc_prev) begin
                pulses++;
                if (pulses > 1 && low_run < 2) gap_bad++;
            end
            low_run = bus.wb_cyc_o ? 0 : low_run + 1;
            cyc_prev = bus.wb_cyc_o;
            if ((bus.wb_cyc_o || bus.rsp_valid_o) && bus.cmd_ready_o) rdy_bad++;
            if (bus.rsp_valid_o && bus.rsp_ready_i) rq.push_back(bus.rsp_data_o);
        end
    end

    task automatic set_cmd(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        bus.cmd_addr_i = a;
        bus.cmd_data_i = d;
        bus.cmd_we_i   = w;
        bus.cmd_sel_i  = s;
    endtask

    // returns at the negedge right after the handshake edge
    task automatic start_cmd(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        int n;
        @(negedge clk);
        set_cmd(a, d, w, s);
        bus.cmd_valid_i = 1'b1;
        n = 0;
        while (!bus.cmd_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
        int          dly;
        logic        err;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt [9];

    initial begin
        int n;
        int bad;
        vt[0] = '{32'h08, 32'h0000_0010, 1'b1, 4'hF, 0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{32'h08, 32'hDEAD_BEEF, 1'b0, 4'hF, 0, 1'b0, 1'b0, 32'h0000_0010};
        vt[2] = '{32'h0C, 32'hAABB_CCDD, 1'b1, 4'h5, 1, 1'b0, 1'b0, 32'h0};
        vt[3] = '{32'h0C, 32'h0,         1'b0, 4'hF, 2, 1'b0, 1'b0, 32'h00BB_00DD};
        vt[4] = '{32'h08, 32'h0,         1'b0, 4'hF, 0, 1'b1, 1'b1, 32'h0};
        vt[5] = '{32'h10, 32'h1234_5678, 1'b1, 4'hF, 1, 1'b1, 1'b1, 32'h0};
        vt[6] = '{32'h10, 32'h0,         1'b0, 4'hF, 0, 1'b0, 1'b0, 32'h0};
        vt[7] = '{32'h0C, 32'h1122_3344, 1'b1, 4'h2, 3, 1'b0, 1'b0, 32'h0};
        vt[8] = '{32'h0C, 32'h0,         1'b0, 4'hF, 0, 1'b0, 1'b0, 32'h00BB_33DD};

        bus.cmd_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        set_cmd('0, '0, 1'b0, '0);
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
        chk("rst_addr", bus.wb_addr_o, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_rsp_data", bus.rsp_data_o, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
        rst_n = 1'b1;

        ack_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            delay = vt[i].dly;
            err_mode = vt[i].err;
            start_cmd(vt[i].addr, vt[i].data, vt[i].we, vt[i].sel);
            chk($sformatf("v%0d_cyc", i), 32'(bus.wb_cyc_o & bus.wb_stb_o), 32'd1);
            chk($sformatf("v%0d_addr", i), bus.wb_addr_o, vt[i].addr);
            chk($sformatf("v%0d_wdata", i), bus.wb_data_o, vt[i].data);
            chk($sformatf("v%0d_we_sel", i), {27'd0, bus.wb_we_o, bus.wb_sel_o}, {27'd0, vt[i].we, vt[i].sel});
            n = 1;
            while (!bus.rsp_valid_o && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("v%0d_latency", i), 32'(n), 32'(vt[i].dly + 2));
            chk($sformatf("v%0d_rsp_err", i), 32'(bus.rsp_err_o), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_rsp_data", i), bus.rsp_data_o, vt[i].exp_data);
            chk($sformatf("v%0d_cyc_drop", i), 32'(bus.wb_cyc_o), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_rsp_done", i), 32'(bus.rsp_valid_o), 32'd0);
        end
        err_mode = 1'b0;
        delay = 0;

        // back-to-back: valid held high across three commands
        mon = 1'b1;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_cmd(32'h08 + 32'(4 * i), '0, 1'b0, 4'hF);
            n = 0;
            while (!bus.cmd_ready_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        bus.cmd_valid_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_gap", 32'(gap_bad), 32'd0);
        chk("b2b_ready_low", 32'(rdy_bad), 32'd0);
        chk("b2b_rsp_count", 32'(rq.size()), 32'd3);
        if (rq.size() == 3) begin
            chk("b2b_rsp0", rq[0], 32'h0000_0010);
            chk("b2b_rsp1", rq[1], 32'h00BB_33DD);
            chk("b2b_rsp2", rq[2], 32'h0);
        end
        mon = 1'b0;

        // response backpressure with a command offered during the stall
        bus.rsp_ready_i = 1'b0;
        start_cmd(32'h08, '0, 1'b0, 4'hF);
        set_cmd(32'h0C, '0, 1'b0, 4'hF);
        bus.cmd_valid_i = 1'b1;
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!bus.rsp_valid_o || bus.rsp_data_o !== 32'h10 || bus.rsp_err_o || bus.cmd_ready_o || bus.wb_cyc_o)
                bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        bus.rsp_ready_i = 1'b1;
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("bp_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("bp_data_kept", bus.rsp_data_o, 32'h10);

        // stray ack while idle
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.wb_cyc_o || !bus.cmd_ready_o) bad++;
        end
        chk("stray_ack", 32'(bad), 32'd0);

        // responder never acks
        ack_en = 1'b0;
        start_cmd(32'h20, 32'h5555_AAAA, 1'b0, 4'hF);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        n = 0;
        while (bus.wb_cyc_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("to_bus_cycles", 32'(n), 32'd5);
        chk("to_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        chk("to_rsp_err", 32'(bus.rsp_err_o), 32'd1);
        chk("to_rsp_data", bus.rsp_data_o, 32'd0);
        start_cmd(32'h24, '0, 1'b0, 4'hF);
        @(negedge clk);
`else
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.wb_cyc_o || bus.rsp_valid_o) bad++;
        end
        chk("hang_wait", 32'(bad), 32'd0);
`endif

        // reset in the middle of BUS
        chk("pre_rst_cyc", 32'(bus.wb_cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(bus.wb_cyc_o | bus.wb_stb_o), 32'd0);
        chk("mid_rst_ready", 32'(bus.cmd_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.rsp_valid_o || bus.wb_cyc_o || bus.rsp_err_o) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
